// File: rtl/simple_phase_sequencer.sv
// Run/step/halt sequencer for the SIMPLE five-phase datapath.
// Drives the one-hot phase enables and gates instruction issue.
module simple_phase_sequencer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_run_sw,
  input  logic        i_step,
  input  logic        i_halt_req,
  input  logic        i_resume,
  input  logic        i_stall,
  output logic [4:0]  o_phase,
  output logic        o_busy,
  output logic        o_halted,
  output logic        o_instr_done,
  output logic [15:0] o_instr_count
);

  typedef enum logic [1:0] {StIdle, StRun, StStep, StHalted} state_e;

  state_e      r_state;
  logic [4:0]  r_phase;
  logic        r_done;
  logic [15:0] r_count;

  state_e      w_state_d;
  logic [4:0]  w_phase_d;
  logic        w_done_d;
  logic [15:0] w_count_d;
  logic        w_retire;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_phase <= 5'b0;
      r_done  <= 1'b0;
      r_count <= 16'h0;
    end else begin
      r_state <= w_state_d;
      r_phase <= w_phase_d;
      r_done  <= w_done_d;
      r_count <= w_count_d;
    end
  end

  // P5 completing on this edge; only meaningful while busy.
  assign w_retire = r_phase[4] && !i_stall;

  always_comb begin
    w_state_d = r_state;
    w_phase_d = r_phase;
    w_done_d  = 1'b0;
    w_count_d = r_count;
    unique case (r_state)
      StIdle: begin
        if (i_run_sw) begin
          w_state_d = StRun;
          w_phase_d = 5'b00001;
        end else if (i_step) begin
          w_state_d = StStep;
          w_phase_d = 5'b00001;
        end
      end
      StRun, StStep: begin
        if (w_retire) begin
          w_count_d = r_count + 16'd1;
          w_done_d  = 1'b1;
          if (i_halt_req) begin
            w_state_d = StHalted;
            w_phase_d = 5'b0;
          end else if (r_state == StRun && i_run_sw) begin
            w_phase_d = 5'b00001;
          end else begin
            w_state_d = StIdle;
            w_phase_d = 5'b0;
          end
        end else if (!i_stall) begin
          w_phase_d = {r_phase[3:0], r_phase[4]};
        end
      end
      StHalted: begin
        w_phase_d = 5'b0;
        if (i_resume) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_phase_d = 5'b0;
      end
    endcase
  end

  assign o_phase       = r_phase;
  assign o_busy        = (r_state == StRun) || (r_state == StStep);
  assign o_halted      = (r_state == StHalted);
  assign o_instr_done  = r_done;
  assign o_instr_count = r_count;

endmodule

// File: tb/tb_simple_phase_sequencer.sv
// Directed self-checking bench for simple_phase_sequencer.
module tb_simple_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, run_sw, step, halt_req, resume, stall;
  logic [4:0]  phase;
  logic        busy, halted, instr_done;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  simple_phase_sequencer dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_run_sw      (run_sw),
    .i_step        (step),
    .i_halt_req    (halt_req),
    .i_resume      (resume),
    .i_stall       (stall),
    .o_phase       (phase),
    .o_busy        (busy),
    .o_halted      (halted),
    .o_instr_done  (instr_done),
    .o_instr_count (instr_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [4:0] e_phase, input logic e_busy,
                            input logic e_halted, input logic e_done, input logic [15:0] e_count);
    check_eq({tag, ".phase"}, 32'(phase), 32'(e_phase));
    check_eq({tag, ".busy"}, 32'(busy), 32'(e_busy));
    check_eq({tag, ".halted"}, 32'(halted), 32'(e_halted));
    check_eq({tag, ".done"}, 32'(instr_done), 32'(e_done));
    check_eq({tag, ".count"}, 32'(instr_count), 32'(e_count));
  endtask

  initial begin
    rst_n = 1'b0; run_sw = 1'b0; step = 1'b0;
    halt_req = 1'b0; resume = 1'b0; stall = 1'b0;
    tick();
    tick();
    expect_all("reset", 5'h00, 1'b0, 1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;
    tick();
    expect_all("idle", 5'h00, 1'b0, 1'b0, 1'b0, 16'd0);

    // Continuous run; run_sw dropped while the 3rd instruction is in P1.
    run_sw = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_eq($sformatf("run%0d.phase", k), 32'(phase), 32'(5'b1 << ((k - 1) % 5)));
      check_eq($sformatf("run%0d.done", k), 32'(instr_done), 32'(k == 6 || k == 11));
      if (k == 11) run_sw = 1'b0;
    end
    check_eq("run.count", 32'(instr_count), 32'd2);
    tick(); check_eq("drop.p3", 32'(phase), 32'h04);
    tick(); check_eq("drop.p4", 32'(phase), 32'h08);
    tick(); check_eq("drop.p5", 32'(phase), 32'h10);
    tick(); expect_all("drop.end", 5'h00, 1'b0, 1'b0, 1'b1, 16'd3);
    tick(); expect_all("drop.idle", 5'h00, 1'b0, 1'b0, 1'b0, 16'd3);

    // Single step; second pulse during P3 is dropped.
    step = 1'b1;
    tick(); expect_all("step.p1", 5'h01, 1'b1, 1'b0, 1'b0, 16'd3);
    step = 1'b0;
    tick(); check_eq("step.p2", 32'(phase), 32'h02);
    tick(); check_eq("step.p3", 32'(phase), 32'h04);
    step = 1'b1;
    tick(); check_eq("step.p4", 32'(phase), 32'h08);
    step = 1'b0;
    tick(); check_eq("step.p5", 32'(phase), 32'h10);
    tick(); expect_all("step.end", 5'h00, 1'b0, 1'b0, 1'b1, 16'd4);
    tick(); expect_all("step.noq", 5'h00, 1'b0, 1'b0, 1'b0, 16'd4);

    // Stall three cycles in P3, then also across P5 for one cycle.
    run_sw = 1'b1;
    tick(); check_eq("stall.p1", 32'(phase), 32'h01);
    tick(); check_eq("stall.p2", 32'(phase), 32'h02);
    tick(); check_eq("stall.p3", 32'(phase), 32'h04);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); check_eq($sformatf("stall.hold%0d", k), 32'(phase), 32'h04);
    end
    stall = 1'b0;
    run_sw = 1'b0;
    tick(); check_eq("stall.p4", 32'(phase), 32'h08);
    tick(); check_eq("stall.p5", 32'(phase), 32'h10);
    stall = 1'b1;
    tick(); expect_all("stall.p5hold", 5'h10, 1'b1, 1'b0, 1'b0, 16'd4);
    stall = 1'b0;
    tick(); expect_all("stall.end", 5'h00, 1'b0, 1'b0, 1'b1, 16'd5);

    // Halt requested during P2; run_sw/step ignored while halted.
    run_sw = 1'b1;
    tick(); check_eq("halt.p1", 32'(phase), 32'h01);
    tick(); check_eq("halt.p2", 32'(phase), 32'h02);
    halt_req = 1'b1;
    tick(); check_eq("halt.p3", 32'(phase), 32'h04);
    tick(); check_eq("halt.p4", 32'(phase), 32'h08);
    tick(); check_eq("halt.p5", 32'(phase), 32'h10);
    step = 1'b1;
    tick(); expect_all("halt.enter", 5'h00, 1'b0, 1'b1, 1'b1, 16'd6);
    halt_req = 1'b0;
    stall = 1'b1;
    tick(); expect_all("halt.stay", 5'h00, 1'b0, 1'b1, 1'b0, 16'd6);
    step = 1'b0;
    stall = 1'b0;
    resume = 1'b1;
    tick(); expect_all("halt.resume", 5'h00, 1'b0, 1'b0, 1'b0, 16'd6);
    resume = 1'b0;
    tick(); expect_all("halt.rerun", 5'h01, 1'b1, 1'b0, 1'b0, 16'd6);

    // Reset mid-instruction while stalled in P4.
    tick(); check_eq("rst.p2", 32'(phase), 32'h02);
    tick(); check_eq("rst.p3", 32'(phase), 32'h04);
    tick(); check_eq("rst.p4", 32'(phase), 32'h08);
    stall = 1'b1;
    rst_n = 1'b0;
    tick(); expect_all("rst.mid", 5'h00, 1'b0, 1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;
    stall = 1'b0;
    run_sw = 1'b0;
    tick(); expect_all("rst.idle", 5'h00, 1'b0, 1'b0, 1'b0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simple_phase_sequencer.md
# simple_phase_sequencer

Run/step/halt sequencer for the SIMPLE five-phase processor datapath. It generates the one-hot phase enables that clock IR, AR/BR, DR, MDR/register file and PC, and gates instruction issue from a run switch, a single-step pulse and the decoder's halt request. A memory-wait stall freezes the current phase. It replaces the free-running phase counter at the top level.

## Interface
- No parameters; phase count fixed at 5, instruction counter fixed at 16 bits.
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- run_sw  in  1  level; 1 = run continuously, 0 = stop at next instruction boundary
- step  in  1  one-cycle pulse (from the debounced exec button); execute exactly one instruction
- halt_req  in  1  level from decoder; HLT instruction in flight
- resume  in  1  one-cycle pulse; leave HALTED
- stall  in  1  level; 1 = hold current phase (memory not ready)
- phase  out  5  one-hot phase: bit0 P1 IR load, bit1 P2 AR/BR, bit2 P3 ALU/DR, bit3 P4 MDR/RF write, bit4 P5 PC update; 0 when not executing
- busy  out  1  1 in RUN or STEP
- halted  out  1  1 in HALTED
- instr_done  out  1  registered one-cycle pulse after each completed P5
- instr_count  out  16  completed instructions since reset

## Operation
- States: IDLE, RUN, STEP, HALTED. Reset: IDLE, phase=0, busy=0, halted=0, instr_done=0, instr_count=0.
- IDLE: run_sw=1 -> RUN, phase<=00001. Else step=1 -> STEP, phase<=00001. run_sw has precedence when both high. resume ignored.
- RUN/STEP advance: stall=0 -> phase rotates left one bit per cycle (P1->P2->...->P5); stall=1 -> phase and state hold, no other effect.
- End of instruction = edge with phase[4]=1 and stall=0 ("P5 retire"). On retire: instr_count+1 (wraps FFFF->0000), instr_done=1 next cycle, then:
  - halt_req=1 -> HALTED, phase<=0 (highest priority, both RUN and STEP)
  - else RUN with run_sw=1 -> phase<=00001, stay RUN
  - else RUN with run_sw=0 -> IDLE, phase<=0
  - else STEP -> IDLE, phase<=0
- halt_req and run_sw are sampled only on the retire edge; mid-instruction changes do not cut the instruction short.
- step pulses while busy or HALTED are dropped, not queued.
- HALTED: phase=0, halted=1; run_sw and step ignored; resume=1 -> IDLE next edge (halted=0). Leaving IDLE again needs run_sw or step.
- stall while IDLE or HALTED: no effect.
- Exactly one phase bit high whenever busy=1; phase=0 whenever busy=0.

## Timing
- Issue latency: run_sw/step sampled at edge N -> phase=00001 and busy=1 after edge N.
- Unstalled instruction: 5 cycles, P1..P5; in RUN, back-to-back instructions with no gap (P5 -> P1 on the next edge).
- Each stall cycle adds one cycle to the phase it occurs in.
- instr_done high for exactly the cycle after the retire edge; instr_count already updated in that cycle.
- rst_n=0 at any edge, including mid-instruction or stalled: all outputs at reset values after that edge; no partial retire counted.
- All outputs registered; no combinational input-to-output paths.

## Test plan
- Reset then run_sw=1 for 12 cycles: phase = 01,02,04,08,10,01,02,... ; instr_done pulses after cycles 5 and 10; instr_count=2.
- IDLE, step pulse: phase 01..10 once, then 0 and IDLE; instr_count=1. Second step during P3: ignored, count stays 1.
- RUN, stall=1 for 3 cycles while phase=04: phase holds 04 for 4 cycles total; instruction takes 8 cycles; count +1 only.
- RUN, halt_req raised during P2 with run_sw=1: completes through P5, then phase=0, halted=1, count+1; run_sw/step ignored; resume pulse -> IDLE, then RUN one cycle later because run_sw=1.
- RUN, run_sw dropped during P1: instruction finishes P5, then IDLE, phase=0, busy=0.
- rst_n=0 with phase=08 and instr_count=0x0003: next cycle phase=0, instr_count=0, IDLE. Separately, preload 0xFFFF retires -> count wraps to 0x0000.
